// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and the result-flag bundle.
// Used by the sequential ALU and by the UART/ALU bridge.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b011001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic neg;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle of the sequential ALU.
// The master offers operands and consumes results; the slave is the ALU.
interface alu_seq_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_data_a;
    logic [NB_DATA-1:0] i_data_b;
    logic [NB_OP-1:0]   i_op;
    logic               i_valid;
    logic               o_in_ready;
    logic [NB_DATA-1:0] o_data;
    logic [NB_DATA-1:0] o_data_hi;
    logic               o_carry;
    logic               o_zero;
    logic               o_ovf;
    logic               o_neg;
    logic               o_err;
    logic               o_valid;
    logic               i_out_ready;

    modport master (
        output i_data_a, i_data_b, i_op, i_valid, i_out_ready,
        input  o_in_ready, o_data, o_data_hi, o_carry, o_zero, o_ovf, o_neg, o_err, o_valid
    );

    modport slave (
        input  i_data_a, i_data_b, i_op, i_valid, i_out_ready,
        output o_in_ready, o_data, o_data_hi, o_carry, o_zero, o_ovf, o_neg, o_err, o_valid
    );
endinterface

// File: rtl/alu_multu.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// The start cycle already performs the first step, so the product is ready NB_DATA cycles after start.
module alu_multu #(
    parameter int NB_DATA = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_a,
    input  logic [NB_DATA-1:0]     i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [2*NB_DATA-1:0]   o_product
);
    localparam int NB_CNT = $clog2(NB_DATA + 1);

    logic [2*NB_DATA-1:0] mcand_q, mcand_d, mcand_src;
    logic [2*NB_DATA-1:0] acc_q, acc_d, acc_src;
    logic [NB_DATA-1:0]   mplier_q, mplier_d, mplier_src;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 step;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        mcand_src  = i_start ? {{NB_DATA{1'b0}}, i_a} : mcand_q;
        mplier_src = i_start ? i_b : mplier_q;
        acc_src    = i_start ? '0 : acc_q;
        step       = i_start || (cnt_q != '0);

        if (step) begin
            acc_d    = mplier_src[0] ? (acc_src + mcand_src) : acc_src;
            mcand_d  = mcand_src << 1;
            mplier_d = mplier_src >> 1;
            cnt_d    = i_start ? NB_CNT'(NB_DATA - 1) : (cnt_q - NB_CNT'(1));
            done_d   = (cnt_d == '0);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign o_busy    = (cnt_q != '0);
    assign o_done    = done_q;
    assign o_product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus a multi-cycle unsigned multiply,
// with a valid/ready handshake on both the operand and the result side.
module alu_seq
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic      i_clk,
    input  logic      i_reset,
    alu_seq_if.slave  bus
);
    localparam int NB_SHAMT = $clog2(NB_DATA);

    logic [1:0]           state_q, state_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic [NB_DATA-1:0]   data_hi_q, data_hi_d;
    alu_flags_t           flags_q, flags_d;

    logic [NB_DATA-1:0]   alu_res;
    alu_flags_t           alu_flags;
    logic [NB_DATA:0]     wide;
    logic [NB_SHAMT-1:0]  shamt;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*NB_DATA-1:0] mul_product;

    assign accept    = bus.i_valid && bus.o_in_ready;
    assign mul_start = accept && (bus.i_op == NB_OP'(OP_MULTU));

    // The multiplier captures A and B itself on the accept edge.
    alu_multu #(.NB_DATA(NB_DATA)) u_multu (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (mul_start),
        .i_a       (bus.i_data_a),
        .i_b       (bus.i_data_b),
        .o_busy    (mul_busy),
        .o_done    (mul_done),
        .o_product (mul_product)
    );

    // Single-cycle datapath, evaluated on the offered operands so the result lands on the accept edge.
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        wide      = '0;
        shamt     = bus.i_data_b[NB_SHAMT-1:0];

        case (bus.i_op)
            NB_OP'(OP_ADD): begin
                wide            = {1'b0, bus.i_data_a} + {1'b0, bus.i_data_b};
                alu_res         = wide[NB_DATA-1:0];
                alu_flags.carry = wide[NB_DATA];
                alu_flags.ovf   = (bus.i_data_a[NB_DATA-1] == bus.i_data_b[NB_DATA-1]) &&
                                  (wide[NB_DATA-1] != bus.i_data_a[NB_DATA-1]);
            end
            NB_OP'(OP_SUB): begin
                wide            = {1'b0, bus.i_data_a} - {1'b0, bus.i_data_b};
                alu_res         = wide[NB_DATA-1:0];
                alu_flags.carry = wide[NB_DATA];
                alu_flags.ovf   = (bus.i_data_a[NB_DATA-1] != bus.i_data_b[NB_DATA-1]) &&
                                  (wide[NB_DATA-1] != bus.i_data_a[NB_DATA-1]);
            end
            NB_OP'(OP_AND):  alu_res = bus.i_data_a & bus.i_data_b;
            NB_OP'(OP_OR):   alu_res = bus.i_data_a | bus.i_data_b;
            NB_OP'(OP_XOR):  alu_res = bus.i_data_a ^ bus.i_data_b;
            NB_OP'(OP_NOR):  alu_res = ~(bus.i_data_a | bus.i_data_b);
            NB_OP'(OP_SLT):  alu_res = NB_DATA'($signed(bus.i_data_a) < $signed(bus.i_data_b));
            NB_OP'(OP_SLTU): alu_res = NB_DATA'(bus.i_data_a < bus.i_data_b);
            NB_OP'(OP_SLL):  alu_res = bus.i_data_a << shamt;
            NB_OP'(OP_SRL):  alu_res = bus.i_data_a >> shamt;
            NB_OP'(OP_SRA):  alu_res = $unsigned($signed(bus.i_data_a) >>> shamt);
            NB_OP'(OP_MULTU): alu_res = '0;
            default:         alu_flags.err = 1'b1;
        endcase

        alu_flags.zero = (alu_res == '0);
        alu_flags.neg  = alu_res[NB_DATA-1];
    end

    // Result registers move only when DONE is entered.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        data_hi_d = data_hi_q;
        flags_d   = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_BUSY;
                end else if (accept) begin
                    state_d   = ST_DONE;
                    data_d    = alu_res;
                    data_hi_d = '0;
                    flags_d   = alu_flags;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d                = ST_DONE;
                    {data_hi_d, data_d}    = mul_product;
                    flags_d                = '0;
                    flags_d.zero           = (mul_product == '0);
                    flags_d.neg            = mul_product[2*NB_DATA-1];
                end
            end
            ST_DONE: begin
                if (bus.i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            data_hi_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            data_hi_q <= data_hi_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.o_in_ready = (state_q == ST_IDLE) && !mul_busy;
    assign bus.o_valid    = (state_q == ST_DONE);
    assign bus.o_data     = data_q;
    assign bus.o_data_hi  = data_hi_q;
    assign bus.o_carry    = flags_q.carry;
    assign bus.o_zero     = flags_q.zero;
    assign bus.o_ovf      = flags_q.ovf;
    assign bus.o_neg      = flags_q.neg;
    assign bus.o_err      = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (NB_DATA=8) against an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_seq;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [5:0] T_ADD   = 6'b100000;
    localparam logic [5:0] T_SUB   = 6'b100010;
    localparam logic [5:0] T_AND   = 6'b100100;
    localparam logic [5:0] T_OR    = 6'b100101;
    localparam logic [5:0] T_XOR   = 6'b100110;
    localparam logic [5:0] T_NOR   = 6'b100111;
    localparam logic [5:0] T_SLT   = 6'b101010;
    localparam logic [5:0] T_SLTU  = 6'b101011;
    localparam logic [5:0] T_SLL   = 6'b000000;
    localparam logic [5:0] T_SRL   = 6'b000010;
    localparam logic [5:0] T_SRA   = 6'b000011;
    localparam logic [5:0] T_MULTU = 6'b011001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_seq #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        bit         carry;
        bit         zero;
        bit         ovf;
        bit         neg;
        bit         err;
        int         lat;
    } exp_t;

    function automatic bit is_listed(input logic [5:0] op);
        logic [5:0] ops [12] = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR,
                                 T_SLT, T_SLTU, T_SLL, T_SRL, T_SRA, T_MULTU};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: plain integer arithmetic on unsigned/signed views of the operands.
    function automatic exp_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = (ua > 127) ? ua - 256 : ua;
        int sb = (ub > 127) ? ub - 256 : ub;
        int amt = ub % 8;
        int r = 0;
        int hi = 0;
        e.carry = 0; e.ovf = 0; e.err = 0; e.lat = 1;
        case (op)
            T_ADD:   begin r = ua + ub; e.carry = (r > 255); e.ovf = (sa + sb > 127) || (sa + sb < -128); end
            T_SUB:   begin r = ua - ub; e.carry = (r < 0);   e.ovf = (sa - sb > 127) || (sa - sb < -128); end
            T_AND:   r = ua & ub;
            T_OR:    r = ua | ub;
            T_XOR:   r = ua ^ ub;
            T_NOR:   r = ~(ua | ub);
            T_SLT:   r = (sa < sb) ? 1 : 0;
            T_SLTU:  r = (ua < ub) ? 1 : 0;
            T_SLL:   r = ua << amt;
            T_SRL:   r = ua >> amt;
            T_SRA:   r = sa >>> amt;
            T_MULTU: begin r = ua * ub; hi = r / 256; e.lat = 9; end
            default: e.err = 1;
        endcase
        e.lo   = 8'(r);
        e.hi   = 8'(hi);
        e.zero = (e.lo == 0) && (e.hi == 0);
        e.neg  = (op == T_MULTU) ? e.hi[7] : e.lo[7];
        return e;
    endfunction

    function automatic logic [63:0] observed();
        return 64'({bus.o_data_hi, bus.o_data, bus.o_carry, bus.o_zero, bus.o_ovf, bus.o_neg, bus.o_err});
    endfunction

    task automatic jiggle_inputs();
        bus.i_valid  = 1'($urandom_range(0, 1));
        bus.i_data_a = 8'($urandom);
        bus.i_data_b = 8'($urandom);
        bus.i_op     = 6'($urandom);
    endtask

    // Offer one op at a falling edge, wait for o_valid, hold the result `hold` cycles, then consume it.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold, input bit noise);
        exp_t        e = model(op, a, b);
        logic [63:0] want = 64'({e.hi, e.lo, e.carry, e.zero, e.ovf, e.neg, e.err});
        int          lat;
        check({tag, " in_ready before"}, 64'(bus.o_in_ready), 64'(1));
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_op     = op;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 40) begin
            check({tag, " in_ready busy"}, 64'(bus.o_in_ready), 64'(0));
            if (noise) jiggle_inputs();
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        for (int i = 0; i <= hold; i++) begin
            check({tag, " result"}, observed(), want);
            check({tag, " valid/in_ready held"}, 64'({bus.o_valid, bus.o_in_ready}), 64'(2'b10));
            if (i == hold) begin
                bus.i_valid     = 1'b0;
                bus.i_out_ready = 1'b1;
            end else if (noise) begin
                jiggle_inputs();
            end
            @(negedge clk);
        end
        bus.i_out_ready = 1'b0;
        check({tag, " consumed"}, 64'({bus.o_valid, bus.o_in_ready}), 64'(2'b01));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [12] = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR,
                                 T_SLT, T_SLTU, T_SLL, T_SRL, T_SRA, T_MULTU};
        logic [5:0] rop;

        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_out_ready = 1'b0;
        bus.i_data_a    = '0;
        bus.i_data_b    = '0;
        bus.i_op        = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", observed(), 64'(0));
        check("reset valid", 64'(bus.o_valid), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", 64'(bus.o_in_ready), 64'(1));

        run_op("add ff+01",   T_ADD,   8'hFF, 8'h01, 0, 0);
        run_op("sub 80-01",   T_SUB,   8'h80, 8'h01, 0, 0);
        run_op("sub 00-01",   T_SUB,   8'h00, 8'h01, 0, 0);
        run_op("sra 80>>>3",  T_SRA,   8'h80, 8'h03, 0, 0);
        run_op("srl 80>>3",   T_SRL,   8'h80, 8'h03, 0, 0);
        run_op("sll 81<<1",   T_SLL,   8'h81, 8'h01, 0, 0);
        run_op("slt ff,01",   T_SLT,   8'hFF, 8'h01, 0, 0);
        run_op("sltu ff,01",  T_SLTU,  8'hFF, 8'h01, 0, 0);
        run_op("multu ff*ff", T_MULTU, 8'hFF, 8'hFF, 0, 1);
        run_op("add hold5",   T_ADD,   8'h12, 8'h34, 5, 1);
        run_op("unknown 3f",  6'h3F,   8'h5A, 8'hA5, 0, 0);
        run_op("multu 0*x",   T_MULTU, 8'h00, 8'h9C, 2, 1);

        // Reset four cycles into a multiply: the result must never appear.
        bus.i_data_a = 8'hFF;
        bus.i_data_b = 8'hFF;
        bus.i_op     = T_MULTU;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-busy reset outputs", observed(), 64'(0));
        check("mid-busy reset valid", 64'(bus.o_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after abort", 64'(bus.o_in_ready), 64'(1));
        for (int i = 0; i < 12; i++) begin
            check("no valid after abort", 64'({bus.o_valid, observed()}), 64'(0));
            @(negedge clk);
        end

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do rop = 6'($urandom); while (is_listed(rop));
            end else begin
                rop = ops[$urandom_range(0, 11)];
            end
            run_op($sformatf("rand%0d op%02h", n, rop), rop, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result width; SHALL be at least 4.
REQ-002 Parameter NB_OP, default 6, operation-code width.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous and active-high.
REQ-005 i_data_a  input  NB_DATA  operand A.
REQ-006 i_data_b  input  NB_DATA  operand B; also the shift amount.
REQ-007 i_op  input  NB_OP  operation code.
REQ-008 i_valid  input  1  operands and op are offered.
REQ-009 o_in_ready  output  1  block accepts an operation this cycle.
REQ-010 o_data  output  NB_DATA  result, low half for MULTU.
REQ-011 o_data_hi  output  NB_DATA  MULTU high half; 0 for every other op.
REQ-012 o_carry, o_zero, o_ovf, o_neg, o_err  output  1 each  result flags.
REQ-013 o_valid  output  1  result and flags are valid.
REQ-014 i_out_ready  input  1  consumer takes the result.

Function
REQ-015 FSM states IDLE, BUSY, DONE; o_in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = i_valid & o_in_ready; on accept, i_data_a, i_data_b and i_op SHALL be registered.
REQ-017 Single-cycle ops: IDLE->DONE on accept; o_valid SHALL rise at the first edge after the accept edge (latency 1).
REQ-018 MULTU (011001): IDLE->BUSY; unsigned shift-add, one bit per cycle, NB_DATA iterations, then DONE; o_valid SHALL rise at accept+NB_DATA+1.
REQ-019 DONE: o_valid=1; all outputs SHALL be held stable until i_out_ready=1, then DONE->IDLE on that edge.
REQ-020 i_valid in BUSY/DONE SHALL be ignored, with no state change.
REQ-021 Op codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, MULTU 011001.
REQ-022 ADD: o_carry = bit NB_DATA of the (NB_DATA+1)-bit unsigned sum.
REQ-023 SUB: o_carry = bit NB_DATA of {0,A}-{0,B}, i.e. 1 on borrow.
REQ-024 ADD/SUB: o_ovf = two's-complement signed overflow.
REQ-025 All other ops: o_carry=0 and o_ovf=0.
REQ-026 SLT: o_data = 1 if A<B signed, else 0; SLTU: the same test unsigned.
REQ-027 Shifts: amount = i_data_b[clog2(NB_DATA)-1:0]; SRA SHALL replicate A's MSB; SLL/SRL SHALL fill zeros.
REQ-028 o_zero=1 iff {o_data_hi,o_data}==0; o_neg = MSB of o_data (of o_data_hi for MULTU).
REQ-029 Unknown op: o_data=0, o_data_hi=0, o_err=1, o_zero=1, other flags 0; latency 1.
REQ-030 o_err SHALL be 0 for every listed op.
REQ-031 Outputs other than o_in_ready/o_valid SHALL be registered and change only on DONE entry or reset.

Reset
REQ-032 i_reset SHALL asynchronously force IDLE and clear the multiplier counter and accumulator.
REQ-033 During reset, o_data, o_data_hi, all flags and o_valid SHALL be 0.
REQ-034 Reset mid-BUSY or mid-DONE SHALL abort the operation with no o_valid pulse; o_in_ready=1 on the first edge after deassertion.

Structure
REQ-035 Op codes and state encoding SHALL live in shared package alu_pkg, reused by the UART/ALU interface.
REQ-036 The shift-add multiplier SHALL be sub-module alu_multu (start/busy/done, NB_DATA parameter); all else stays in alu_seq.

Verification (NB_DATA=8)
REQ-037 ADD A=0xFF, B=0x01 -> o_data=0x00, carry=1, zero=1, ovf=0; o_valid one cycle after accept.
REQ-038 SUB A=0x80, B=0x01 -> 0x7F, carry=0, ovf=1; SUB 0x00-0x01 -> 0xFF, carry=1, neg=1.
REQ-039 SRA 0x80 by 3 -> 0xF0; SRL -> 0x10; SLL 0x81 by 1 -> 0x02; SLT 0xFF vs 0x01 -> 1; SLTU -> 0.
REQ-040 MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, o_valid at accept+9; i_valid pulses while BUSY are ignored.
REQ-041 i_out_ready low 5 cycles in DONE -> outputs stable and o_in_ready=0 throughout; consumed on the 6th cycle.
REQ-042 Reset at accept+4 of MULTU -> outputs 0 and no o_valid; op 111111 -> o_err=1, o_data=0, o_zero=1.
